// File: rtl/freq_synth_pkg.sv
// Shared types and constants for the freq_synth programmable square-wave generator.
package freq_synth_pkg;

  typedef enum logic [2:0] {IDLE, CONV, SCALE, DIV, COMMIT} fsm_state_e;

  localparam int BCD_DIGITS    = 4;
  localparam int RANGE_HI_MULT = 100;
  localparam int ACC_W         = 14;  // 0..9999
  localparam int FREQ_W        = 20;  // up to 999900 Hz
  localparam int DIVISOR_W     = 21;  // 2*f

  // Smallest width w such that clk_hz < 2**w.
  function automatic int div_w_for(input longint clk_hz);
    int w;
    w = 0;
    for (int i = 62; i >= 1; i--) begin
      if ((longint'(1) << i) > clk_hz) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/freq_synth_if.sv
// Setpoint/status bundle of freq_synth, plus the FSM state for observation.
interface freq_synth_if;
  import freq_synth_pkg::*;

  // load is a one-cycle request carrying d3..d0/range_hi; the block is ready
  // exactly when busy is low, and a load seen while busy is high is dropped.
  logic       load;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       range_hi;
  logic       sigout;
  logic       busy;
  logic       running;
  logic       err;
  fsm_state_e state;

  modport master (
    output load, d3, d2, d1, d0, range_hi,
    input  sigout, busy, running, err, state
  );

  modport slave (
    input  load, d3, d2, d1, d0, range_hi,
    output sigout, busy, running, err, state
  );

endinterface

// File: rtl/freq_synth_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// done is high during the final iteration; quotient is valid the cycle after.
module seq_divider #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [20:0]      divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] q;
  logic [20:0]      rem;
  logic [CNT_W-1:0] cnt;
  logic [21:0]      shifted;
  logic [20:0]      diff;
  logic             fits;

  // The partial remainder stays below the divisor, so 21 bits hold it.
  assign shifted = {rem, q[DIV_W-1]};
  assign fits    = shifted >= {1'b0, divisor};
  assign diff    = shifted[20:0] - divisor;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q   <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (start) begin
      q   <= dividend;
      rem <= '0;
      cnt <= CNT_W'(DIV_W);
    end else if (cnt != '0) begin
      rem <= fits ? diff : shifted[20:0];
      q   <= {q[DIV_W-2:0], fits};
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done     = (cnt == CNT_W'(1));
  assign quotient = q;

endmodule

// File: rtl/freq_synth.sv
// Programmable square-wave generator: BCD setpoint -> half-period count -> sigout.
// Build option FREQ_SYNTH_ROUND_EN rounds the half period to nearest (half up).
module freq_synth
  import freq_synth_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int DIV_W  = 27,
  parameter int HALF_W = 26
) (
  input  logic        sysclk,
  input  logic        reset,
  freq_synth_if.slave bus
);
  localparam int IDX_W = $clog2(BCD_DIGITS);

  fsm_state_e           state;
  logic                 busy_q;
  logic                 err_q;
  logic [3:0]           dig [BCD_DIGITS];
  logic                 range_q;
  logic [ACC_W-1:0]     acc;
  logic [IDX_W-1:0]     conv_idx;
  logic [FREQ_W-1:0]    f_q;
  logic [FREQ_W-1:0]    f_next;
  logic                 bad_bcd;
  logic                 div_start;
  logic                 div_done;
  logic [DIV_W-1:0]     dividend;
  logic [DIV_W-1:0]     quotient;
  logic [DIVISOR_W-1:0] divisor;
  logic [HALF_W-1:0]    half;
  logic [HALF_W-1:0]    active_half;
  logic [HALF_W-1:0]    pending_half;
  logic [HALF_W-1:0]    cnt;
  logic                 pending_valid;
  logic                 sigout_q;
  logic                 running_q;

  assign bad_bcd = (bus.d3 > 4'd9) || (bus.d2 > 4'd9) || (bus.d1 > 4'd9) || (bus.d0 > 4'd9);

  // Divider is started from SCALE with the scaled value computed combinationally,
  // so its DIV_W iterations line up exactly with the DIV state.
  assign f_next    = range_q ? FREQ_W'(acc) * FREQ_W'(RANGE_HI_MULT) : FREQ_W'(acc);
  assign divisor   = {f_next, 1'b0};
  assign div_start = (state == SCALE);

`ifdef FREQ_SYNTH_ROUND_EN
  assign dividend = DIV_W'(CLK_HZ) + DIV_W'(f_next);
`else
  assign dividend = DIV_W'(CLK_HZ);
`endif

  assign half = (quotient == '0) ? HALF_W'(1) : quotient[HALF_W-1:0];

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (sysclk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      dig      <= '{default: '0};
      range_q  <= 1'b0;
      acc      <= '0;
      conv_idx <= '0;
      f_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            if (bad_bcd) begin
              err_q <= 1'b1;
            end else begin
              err_q    <= 1'b0;
              dig[0]   <= bus.d3;
              dig[1]   <= bus.d2;
              dig[2]   <= bus.d1;
              dig[3]   <= bus.d0;
              range_q  <= bus.range_hi;
              acc      <= '0;
              conv_idx <= '0;
              busy_q   <= 1'b1;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          acc      <= acc * ACC_W'(10) + ACC_W'(dig[conv_idx]);
          conv_idx <= conv_idx + IDX_W'(1);
          if (conv_idx == IDX_W'(BCD_DIGITS - 1)) state <= SCALE;
        end
        SCALE: begin
          f_q   <= f_next;
          state <= DIV;
        end
        DIV: begin
          if (div_done) state <= COMMIT;
        end
        COMMIT: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Generator. COMMIT updates are written last so they win over a same-cycle toggle.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sigout_q      <= 1'b0;
      running_q     <= 1'b0;
      cnt           <= '0;
      active_half   <= '0;
      pending_half  <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (running_q) begin
        if (cnt == active_half - HALF_W'(1)) begin
          sigout_q <= ~sigout_q;
          cnt      <= '0;
          if (pending_valid) begin
            active_half   <= pending_half;
            pending_valid <= 1'b0;
          end
        end else begin
          cnt <= cnt + HALF_W'(1);
        end
      end
      if (state == COMMIT) begin
        if (f_q == '0) begin
          running_q     <= 1'b0;
          sigout_q      <= 1'b0;
          cnt           <= '0;
          pending_valid <= 1'b0;
        end else if (!running_q) begin
          active_half <= half;
          cnt         <= '0;
          running_q   <= 1'b1;
        end else begin
          pending_half  <= half;
          pending_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.sigout  = sigout_q;
  assign bus.busy    = busy_q;
  assign bus.running = running_q;
  assign bus.err     = err_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_freq_synth.sv
// Self-checking bench for freq_synth at a scaled-down clock rate.
`timescale 1ns/1ps
module tb_freq_synth;
  import freq_synth_pkg::*;

  localparam int CLK_HZ   = 40_000;
  localparam int DIV_W    = div_w_for(CLK_HZ + 999_900);
  localparam int HALF_W   = div_w_for(CLK_HZ / 2);
  localparam int BUSY_CYC = DIV_W + 6;
  localparam int TMO      = 20_000;

  logic sysclk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_q[$];

  freq_synth_if bus ();

  freq_synth #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W), .HALF_W(HALF_W)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  always #5 sysclk = ~sysclk;

  // ---------------- reference model ----------------
  function automatic int model_half(input int val, input bit rh);
    longint f;
    longint q;
    f = rh ? longint'(val) * 100 : longint'(val);
    if (f == 0) return 0;
`ifdef FREQ_SYNTH_ROUND_EN
    q = (longint'(CLK_HZ) + f) / (2 * f);
`else
    q = longint'(CLK_HZ) / (2 * f);
`endif
    if (q < 1) q = 1;
    return int'(q % (longint'(1) << HALF_W));
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_load(input logic [3:0] a3, input logic [3:0] a2,
                         input logic [3:0] a1, input logic [3:0] a0, input logic rh);
    bus.d3 = a3; bus.d2 = a2; bus.d1 = a1; bus.d0 = a0;
    bus.range_hi = rh;
    bus.load = 1'b1;
    @(negedge sysclk);
    bus.load = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      @(negedge sysclk);
      cycles++;
    end
  endtask

  task automatic count_until_change(output int n);
    logic prev;
    prev = bus.sigout;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (bus.sigout === prev && n < TMO);
    if (bus.sigout === prev) n = -1;
  endtask

  task automatic wait_level(input logic v);
    int n;
    n = 0;
    while (bus.sigout !== v && n < TMO) begin
      @(negedge sysclk);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, n2, bc, t, val;
    bit rh, bad, prev_run;
    logic [3:0] dg [4];

    reset = 1'b0;
    bus.load = 1'b1;
    bus.d3 = 4'd1; bus.d2 = 4'd0; bus.d1 = 4'd0; bus.d0 = 4'd0;
    bus.range_hi = 1'b0;
    tick(3);
    check("reset_sigout",  32'(bus.sigout),  32'd0);
    check("reset_busy",    32'(bus.busy),    32'd0);
    check("reset_running", 32'(bus.running), 32'd0);
    check("reset_err",     32'(bus.err),     32'd0);
    check("reset_state",   32'(bus.state),   32'(IDLE));
    bus.load = 1'b0;
    reset = 1'b1;
    tick(1);
    check("post_reset_busy", 32'(bus.busy), 32'd0);

    // 1000 Hz from stopped
    do_load(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_idle(bc);
    check("busy_len_1000", 32'(bc), 32'(BUSY_CYC));
    check("running_1000", 32'(bus.running), 32'd1);
    count_until_change(n);
    check("first_toggle_1000", 32'(n), 32'(model_half(1000, 1'b0)));
    count_until_change(n);
    count_until_change(n2);
    check("half_1000", 32'(n), 32'(model_half(1000, 1'b0)));
    check("period_1000", 32'(n + n2), 32'(2 * model_half(1000, 1'b0)));

    // 500 Hz via high range, loaded while running
    do_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
    wait_idle(bc);
    count_until_change(n);
    count_until_change(n);
    check("half_500_hi", 32'(n), 32'(model_half(5, 1'b1)));

    // 2000 Hz committed in the middle of a high phase
    wait_level(1'b0);
    wait_level(1'b1);
    t = 0;
    tick(2);
    t += 2;
    do_load(4'd2, 4'd0, 4'd0, 4'd0, 1'b0);
    t += 1;
    count_until_change(n);
    check("no_runt_high", 32'(t + n), 32'(model_half(5, 1'b1)));
    count_until_change(n);
    check("new_low_2000", 32'(n), 32'(model_half(2000, 1'b0)));
    count_until_change(n);
    check("new_high_2000", 32'(n), 32'(model_half(2000, 1'b0)));

    // 3 Hz: floor vs round differs here
    do_load(4'd0, 4'd0, 4'd0, 4'd3, 1'b0);
    wait_idle(bc);
    count_until_change(n);
    count_until_change(n);
    check("half_3", 32'(n), 32'(model_half(3, 1'b0)));

    // Non-BCD digit
    do_load(4'd0, 4'd0, 4'hC, 4'd0, 1'b0);
    check("bad_err", 32'(bus.err), 32'd1);
    check("bad_busy", 32'(bus.busy), 32'd0);
    check("bad_running", 32'(bus.running), 32'd1);
    do_load(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    check("clear_err", 32'(bus.err), 32'd0);
    check("clear_busy", 32'(bus.busy), 32'd1);
    wait_idle(bc);
    count_until_change(n);
    count_until_change(n);
    check("half_9999", 32'(n), 32'(model_half(9999, 1'b0)));

    // Maximum frequency: quotient 0 clamps to a 1-cycle half period
    do_load(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
    wait_idle(bc);
    count_until_change(n);
    count_until_change(n);
    count_until_change(n2);
    check("half_max_a", 32'(n), 32'(model_half(9999, 1'b1)));
    check("half_max_b", 32'(n2), 32'(model_half(9999, 1'b1)));

    // Zero stops at once; a load during busy is dropped
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick(3);
    do_load(4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_idle(bc);
    check("zero_sigout",  32'(bus.sigout),  32'd0);
    check("zero_running", 32'(bus.running), 32'd0);
    check("zero_busy",    32'(bus.busy),    32'd0);
    tick(40);
    check("zero_hold_sigout",  32'(bus.sigout),  32'd0);
    check("zero_hold_running", 32'(bus.running), 32'd0);
    check("zero_hold_busy",    32'(bus.busy),    32'd0);

    // Randomised setpoints, some corrupted with a non-BCD digit
    for (int it = 0; it < 10; it++) begin
      rh  = 1'($urandom_range(0, 1));
      val = rh ? int'($urandom_range(1, 9999)) : int'($urandom_range(40, 9999));
      dg[0] = 4'(val / 1000);
      dg[1] = 4'((val / 100) % 10);
      dg[2] = 4'((val / 10) % 10);
      dg[3] = 4'(val % 10);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) dg[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
      if (bad) begin
        prev_run = bus.running;
        do_load(dg[0], dg[1], dg[2], dg[3], rh);
        check("rnd_bad_err", 32'(bus.err), 32'd1);
        check("rnd_bad_busy", 32'(bus.busy), 32'd0);
        check("rnd_bad_running", 32'(bus.running), 32'(prev_run));
      end else begin
        exp_q.push_back(32'(model_half(val, rh)));
        do_load(dg[0], dg[1], dg[2], dg[3], rh);
        check("rnd_err", 32'(bus.err), 32'd0);
        wait_idle(bc);
        check("rnd_busy_len", 32'(bc), 32'(BUSY_CYC));
        count_until_change(n);
        count_until_change(n);
        check("rnd_half", 32'(n), exp_q.pop_front());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
